// File: rtl/btn_press_counter.sv
// Two-button up/down press counter: synchronise and debounce active-low pins, count presses
// modulo MODULUS, light red LED on MATCH and pulse green LED for WRAP_HOLD cycles on every wrap.
module btn_press_counter #(
  parameter int CNT_WIDTH       = 3,
  parameter int MODULUS         = 7,
  parameter int MATCH           = 6,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WRAP_HOLD       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn1_n,
  input  logic                 btn2_n,
  output logic                 led_rgb_red_n,
  output logic                 led_rgb_green_n,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 press_pulse
);

  localparam int SW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(WRAP_HOLD + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = CNT_WIDTH'(MODULUS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MATCH   = CNT_WIDTH'(MATCH);
  localparam logic [SW-1:0]        STABLE_LAST = SW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]        HOLD_LOAD   = HW'(WRAP_HOLD);

  // bit 0 = btn1 (up), bit 1 = btn2 (down)
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] db_q, db_d;
  logic [1:0] db_prev_q, db_prev_d;
  logic [SW-1:0] stable_q [2];
  logic [SW-1:0] stable_d [2];
  logic [1:0] press_ev;

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 press_pulse_q, press_pulse_d;
  logic                 wrap;

  assign sync1_d   = {btn2_n, btn1_n};
  assign sync2_d   = sync1_q;
  assign db_prev_d = db_q;
  assign press_ev  = db_prev_q & ~db_q;

  // stable-counter runs only while the synchronised level disagrees with db
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (stable_q[i] == STABLE_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          stable_d[i] = stable_q[i] + SW'(1);
        end
      end
    end
  end

  always_comb begin
    count_d       = count_q;
    wrap          = 1'b0;
    press_pulse_d = |press_ev;
    case (press_ev)
      2'b01: begin
        if (count_q == CNT_MAX) begin
          count_d = '0;
          wrap    = 1'b1;
        end else begin
          count_d = count_q + CNT_WIDTH'(1);
        end
      end
      2'b10: begin
        if (count_q == '0) begin
          count_d = CNT_MAX;
          wrap    = 1'b1;
        end else begin
          count_d = count_q - CNT_WIDTH'(1);
        end
      end
      default: ;
    endcase

    hold_d = hold_q;
    if (wrap) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 2'b11;
      sync2_q       <= 2'b11;
      db_q          <= 2'b11;
      db_prev_q     <= 2'b11;
      for (int i = 0; i < 2; i++) stable_q[i] <= '0;
      count_q       <= '0;
      hold_q        <= '0;
      press_pulse_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      db_q          <= db_d;
      db_prev_q     <= db_prev_d;
      for (int i = 0; i < 2; i++) stable_q[i] <= stable_d[i];
      count_q       <= count_d;
      hold_q        <= hold_d;
      press_pulse_q <= press_pulse_d;
    end
  end

  assign count           = count_q;
  assign press_pulse     = press_pulse_q;
  assign led_rgb_red_n   = ~(count_q == CNT_MATCH);
  assign led_rgb_green_n = (hold_q == '0);

endmodule

// File: tb/tb_btn_press_counter.sv
// Directed bench for btn_press_counter: default instance plus a MODULUS=2 / DEBOUNCE_CYCLES=1
// instance for back-to-back wrap retrigger.
module tb_btn_press_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_btn1_n = 1'b1, a_btn2_n = 1'b1;
  logic b_btn1_n = 1'b1, b_btn2_n = 1'b1;
  logic a_red_n, a_green_n, a_pulse;
  logic b_red_n, b_green_n, b_pulse;
  logic [2:0] a_count, b_count;

  int n_tests = 0;
  int n_fail  = 0;
  int a_pulse_cnt = 0;
  int a_green_cnt = 0;

  always #5 clk = ~clk;

  btn_press_counter u_dut_a (
    .clk(clk), .rst(rst), .btn1_n(a_btn1_n), .btn2_n(a_btn2_n),
    .led_rgb_red_n(a_red_n), .led_rgb_green_n(a_green_n),
    .count(a_count), .press_pulse(a_pulse)
  );

  btn_press_counter #(.CNT_WIDTH(3), .MODULUS(2), .MATCH(1), .DEBOUNCE_CYCLES(1), .WRAP_HOLD(8)) u_dut_b (
    .clk(clk), .rst(rst), .btn1_n(b_btn1_n), .btn2_n(b_btn2_n),
    .led_rgb_red_n(b_red_n), .led_rgb_green_n(b_green_n),
    .count(b_count), .press_pulse(b_pulse)
  );

  always @(negedge clk) begin
    if (a_pulse === 1'b1) a_pulse_cnt <= a_pulse_cnt + 1;
    if (a_green_n === 1'b0) a_green_cnt <= a_green_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_btn1_n = 1'b1; a_btn2_n = 1'b1; b_btn1_n = 1'b1; b_btn2_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // sel: 1 = btn1, 2 = btn2, 3 = both
  task automatic press_a(input int sel, input int low_cyc, input int high_cyc);
    if (sel[0]) a_btn1_n = 1'b0;
    if (sel[1]) a_btn2_n = 1'b0;
    repeat (low_cyc) @(negedge clk);
    a_btn1_n = 1'b1;
    a_btn2_n = 1'b1;
    repeat (high_cyc) @(negedge clk);
  endtask

  initial begin
    int p0, g0, exp_cnt;

    // reset values
    do_reset();
    check("rst_count", a_count, 0);
    check("rst_pulse", a_pulse, 0);
    check("rst_red", a_red_n, 1);
    check("rst_green", a_green_n, 1);
    check("rst_b_count", b_count, 0);
    check("rst_b_red", b_red_n, 1);
    check("rst_b_green", b_green_n, 1);

    // seven clean up presses with wrap on the last
    p0 = a_pulse_cnt; g0 = a_green_cnt;
    for (int i = 0; i < 7; i++) begin
      press_a(1, 10, 10);
      exp_cnt = (i + 1) % 7;
      check($sformatf("up_count_%0d", i), a_count, exp_cnt);
      check($sformatf("up_red_%0d", i), a_red_n, (exp_cnt == 6) ? 0 : 1);
    end
    check("up_pulses", a_pulse_cnt - p0, 7);
    check("up_green_cycles", a_green_cnt - g0, 8);

    // short glitches rejected
    p0 = a_pulse_cnt;
    for (int i = 0; i < 5; i++) press_a(1, 3, 5);
    check("glitch_count", a_count, 0);
    check("glitch_pulses", a_pulse_cnt - p0, 0);

    // held press: count changes at edge 6 after first low sample
    a_btn1_n = 1'b0;
    repeat (6) @(negedge clk);
    check("lat_count_e5", a_count, 0);
    check("lat_pulse_e5", a_pulse, 0);
    @(negedge clk);
    check("lat_count_e6", a_count, 1);
    check("lat_pulse_e6", a_pulse, 1);
    @(negedge clk);
    check("lat_pulse_e7", a_pulse, 0);
    repeat (30) @(negedge clk);
    check("held_count", a_count, 1);
    a_btn1_n = 1'b1;
    repeat (10) @(negedge clk);

    // down from 0 wraps to 6, then 5
    do_reset();
    g0 = a_green_cnt;
    press_a(2, 10, 10);
    check("dn_wrap_count", a_count, 6);
    check("dn_wrap_red", a_red_n, 0);
    check("dn_wrap_green_cycles", a_green_cnt - g0, 8);
    g0 = a_green_cnt;
    press_a(2, 10, 10);
    check("dn_count", a_count, 5);
    check("dn_red", a_red_n, 1);
    check("dn_green_cycles", a_green_cnt - g0, 0);

    // simultaneous press from 3
    do_reset();
    for (int i = 0; i < 3; i++) press_a(1, 10, 10);
    check("both_pre_count", a_count, 3);
    p0 = a_pulse_cnt; g0 = a_green_cnt;
    press_a(3, 10, 10);
    check("both_count", a_count, 3);
    check("both_pulses", a_pulse_cnt - p0, 1);
    check("both_green_cycles", a_green_cnt - g0, 0);

    // instance B: bring to 1, then up-wrap and down-wrap 4 cycles apart
    b_btn1_n = 1'b0;
    repeat (2) @(negedge clk);
    b_btn1_n = 1'b1;
    repeat (5) @(negedge clk);
    check("b_pre_count", b_count, 1);
    check("b_pre_green", b_green_n, 1);
    for (int k = 0; k < 18; k++) begin
      b_btn1_n = (k == 0 || k == 1) ? 1'b0 : 1'b1;
      b_btn2_n = (k == 4 || k == 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      check($sformatf("b_green_e%0d", k), b_green_n, (k >= 3 && k <= 14) ? 0 : 1);
    end
    check("b_post_count", b_count, 1);

    // reset mid-debounce with hold active, btn1 held through reset
    do_reset();
    a_btn2_n = 1'b0;
    repeat (7) @(negedge clk);
    a_btn2_n = 1'b1;
    a_btn1_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_pre_count", a_count, 6);
    check("mid_pre_green", a_green_n, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_count", a_count, 0);
    check("mid_rst_pulse", a_pulse, 0);
    check("mid_rst_green", a_green_n, 1);
    check("mid_rst_red", a_red_n, 1);
    rst = 1'b0;
    g0 = a_green_cnt; p0 = a_pulse_cnt;
    repeat (6) @(negedge clk);
    check("mid_count_e5", a_count, 0);
    @(negedge clk);
    check("mid_count_e6", a_count, 1);
    check("mid_pulse_e6", a_pulse, 1);
    repeat (20) @(negedge clk);
    check("mid_held_count", a_count, 1);
    check("mid_pulses", a_pulse_cnt - p0, 1);
    check("mid_green_cycles", a_green_cnt - g0, 0);
    a_btn1_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
